fetch_queue_nw: RTL and testbench
=================================

Name: fetch_queue_nw

Overview:
Parametrised N-wide instruction fetch front end that decouples instruction-memory access from decode with an instruction queue. It issues block-aligned fetches to a single wide synchronous BRAM port with 1-cycle read latency. It handles unaligned redirect targets and discards in-flight responses on a redirect. Replaces the fixed 2-wide fetch stage and sits between imem and decode/rename.

Parameters:
FETCH_W, 2, instructions per fetch block and output slots (power of 2, 1..8)
PC_W, 32, PC width
INSTR_W, 32, instruction width
QDEPTH, 8, queue entries (power of 2, >= 2*FETCH_W)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
fetch_en  in  1  permits new imem requests
redirect_en  in  1  flush and restart at redirect_pc
redirect_pc  in  PC_W  redirect target (bits[1:0] ignored)
out_ready  in  1  decode accepts all valid output slots this cycle
if_valid  out  FETCH_W  slot valid mask, contiguous from slot 0
if_pc  out  FETCH_W*PC_W  slot PCs, slot i at [i*PC_W +: PC_W]
if_instr  out  FETCH_W*INSTR_W  slot instructions, same packing
imem_req  out  1  read request
imem_addr  out  PC_W  block-aligned byte address
imem_rdata  in  FETCH_W*INSTR_W  word i = mem[imem_addr+4i], valid the cycle after imem_req
q_count  out  $clog2(QDEPTH)+1  current queue occupancy

Behaviour:
- Reset (reset==0 at edge): pc<=RESET_PC; queue empty; inflight<=0; all outputs 0 (imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, q_count=0).
- Block base = pc with the low log2(FETCH_W*4) bits cleared. Start slot s = pc[log2(FETCH_W*4)-1:2].
- Issue rule: imem_req=1 iff fetch_en && !redirect_en && q_count + (inflight ? FETCH_W : 0) + FETCH_W <= QDEPTH. The dequeue in the same cycle is ignored, which is deliberately conservative.
- On issue: imem_addr=block base; an inflight register captures {base, s}. pc<=base+FETCH_W*4, wrapping modulo 2^PC_W.
- Response: in the cycle after the request, rdata slots s..FETCH_W-1 are enqueued in slot order with pc=base+4i. Slots below s are dropped. Enqueue happens at the end of that cycle. The entries appear on the outputs the next cycle (no bypass).
- Minimum latency: issue at cycle N, data enqueued at end of N+1, visible on if_valid at N+2.
- Output: slot i shows queue entry head+i; if_valid[i]=(q_count>i). When out_ready=1, popcount(if_valid) entries are popped at the edge.
- Simultaneous enqueue and dequeue in the same cycle: q_count updates by the net change. Head and tail pointers wrap modulo QDEPTH.
- Redirect (highest priority): on the edge with redirect_en=1, the queue is flushed (q_count<=0), inflight is cleared, and pc<=redirect_pc. An imem response arriving in that cycle is discarded. There is no imem_req in the redirect cycle; the first request at the new PC is issued the following cycle.
- fetch_en=0: no new requests. An outstanding response is still enqueued and output continues draining.
- Overflow cannot occur under the issue rule. The bench asserts q_count<=QDEPTH and that enqueue never happens when full.
- Empty queue with out_ready=1: no-op.

Optional Feature:
FETCH_PERF_EN
- Defined: adds 32-bit saturating output counters perf_empty_cyc (cycles with q_count==0 && fetch_en) and perf_flush_drop (queue entries plus in-flight slots discarded by redirects). Both clear on reset.
- Undefined: the ports and logic are absent and the core behaviour is identical.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, FETCH_W=2, mem[i]=0x11111111*(i+1) -> first if_valid=2'b11 two cycles after the first request, with PC 0x00/0x04 and instr 0x11111111/0x22222222; then 0x08/0x0C and so on, with no gaps in steady state.
- out_ready=0 held for 10 cycles -> q_count saturates at 8 and imem_req deasserts; releasing out_ready drains 2 per cycle in PC order with none lost or duplicated.
- Redirect to 0x0C while a request is in flight -> the stale response is dropped, imem_addr=0x08, and the output is if_valid=2'b01 with slot0 PC 0x0C instr 0x44444444, then 0x10/0x14.
- Redirect in the same cycle a response arrives and out_ready=1 -> the next cycle shows if_valid=0, and no PC outside the redirect stream ever appears.
- reset asserted while the queue holds 5 entries -> the next cycle has all outputs 0 and pc=RESET_PC; fetching restarts from 0x00.
- FETCH_W=4, QDEPTH=16, pc wraps from 0xFFFFFFF0 -> slots show 0xFFFFFFF0..0xFFFFFFFC, then the next block is 0x00000000.

Source files
------------

// File: rtl/fetch_queue_nw_if.sv
// Fetch front-end bundle: control inputs from the pipeline, imem request and
// response, and the N-wide decode-side output slots.
//   master : driver side (pipeline control, imem response, decode consumer)
//   slave  : the fetch queue itself
interface fetch_queue_nw_if #(
  parameter int FETCH_W = 2,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int QDEPTH  = 8
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic                       fetch_en;
  logic                       redirect_en;
  logic [PC_W-1:0]            redirect_pc;
  logic                       out_ready;
  logic [FETCH_W-1:0]         if_valid;
  logic [FETCH_W*PC_W-1:0]    if_pc;
  logic [FETCH_W*INSTR_W-1:0] if_instr;
  logic                       imem_req;
  logic [PC_W-1:0]            imem_addr;
  logic [FETCH_W*INSTR_W-1:0] imem_rdata;
  logic [CW-1:0]              q_count;

  modport master (
    output fetch_en, redirect_en, redirect_pc, out_ready, imem_rdata,
    input  if_valid, if_pc, if_instr, imem_req, imem_addr, q_count
  );

  modport slave (
    input  fetch_en, redirect_en, redirect_pc, out_ready, imem_rdata,
    output if_valid, if_pc, if_instr, imem_req, imem_addr, q_count
  );
endinterface

// File: rtl/fetch_queue_nw.sv
// N-wide instruction fetch front end with an instruction queue.
// Issues block-aligned reads to a 1-cycle-latency wide BRAM port, enqueues the
// slots from the start slot of the fetch PC upward, and presents up to FETCH_W
// queue entries per cycle to decode. A redirect flushes the queue and drops
// any response that arrives in the redirect cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   bus (slave modport)   fetch_en, redirect_en, redirect_pc, out_ready,
//                         imem_req/imem_addr/imem_rdata, if_valid/if_pc/if_instr,
//                         q_count
//   perf_empty_cyc        (FETCH_PERF_EN only) cycles with empty queue and fetch_en
//   perf_flush_drop       (FETCH_PERF_EN only) entries/slots discarded by redirects
//
// Optional feature macro: FETCH_PERF_EN (saturating performance counters).
module fetch_queue_nw #(
  parameter int              FETCH_W  = 2,
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              QDEPTH   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset,
  fetch_queue_nw_if.slave bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_empty_cyc,
  output logic [31:0] perf_flush_drop
`endif
);

  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam int SW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  localparam logic [PC_W-1:0] OFF_MASK  = PC_W'(FETCH_W * 4 - 1);
  localparam logic [PC_W-1:0] BLK_BYTES = PC_W'(FETCH_W * 4);
  localparam logic [SW-1:0]   SLOT_MASK = SW'(FETCH_W - 1);
  localparam logic [CW-1:0]   FW_C      = CW'(FETCH_W);
  localparam logic [CW:0]     FW_X      = (CW + 1)'(FETCH_W);
  localparam logic [CW:0]     QD_X      = (CW + 1)'(QDEPTH);

  logic [PC_W-1:0]    pc;
  logic [QW-1:0]      head;
  logic [QW-1:0]      tail;
  logic [CW-1:0]      count;
  logic               inflight_v;
  logic [PC_W-1:0]    inflight_base;
  logic [SW-1:0]      inflight_s;

  logic [PC_W-1:0]    q_pc    [QDEPTH];
  logic [INSTR_W-1:0] q_instr [QDEPTH];

  logic [PC_W-1:0]    fetch_base;
  logic [SW-1:0]      start_slot;
  logic [CW:0]        room_need;
  logic               issue;
  logic               resp_take;
  logic [CW-1:0]      enq_n;
  logic [CW-1:0]      out_n;
  logic [CW-1:0]      pop_n;

  assign fetch_base = pc & ~OFF_MASK;
  assign start_slot = SW'(pc >> 2) & SLOT_MASK;

  // Space check counts the outstanding block as a full FETCH_W and ignores
  // this cycle's dequeue, so a response can always be absorbed.
  assign room_need = {1'b0, count} + (inflight_v ? FW_X : '0) + FW_X;
  assign issue     = reset && bus.fetch_en && !bus.redirect_en && (room_need <= QD_X);

  assign resp_take = inflight_v && !bus.redirect_en;
  assign enq_n     = resp_take ? (FW_C - CW'(inflight_s)) : '0;
  assign out_n     = (count > FW_C) ? FW_C : count;
  assign pop_n     = bus.out_ready ? out_n : '0;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = reset ? fetch_base : '0;
  assign bus.q_count   = count;

  // Output slots read straight from the queue; invalid slots are driven to 0.
  always_comb begin
    bus.if_valid = '0;
    bus.if_pc    = '0;
    bus.if_instr = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (count > CW'(i)) begin
        bus.if_valid[i]                  = 1'b1;
        bus.if_pc[i*PC_W +: PC_W]        = q_pc[head + QW'(i)];
        bus.if_instr[i*INSTR_W +: INSTR_W] = q_instr[head + QW'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc            <= RESET_PC;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      inflight_v    <= 1'b0;
      inflight_base <= '0;
      inflight_s    <= '0;
    end else if (bus.redirect_en) begin
      pc         <= {bus.redirect_pc[PC_W-1:2], 2'b00};
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inflight_v <= 1'b0;
    end else begin
      inflight_v <= issue;
      if (issue) begin
        pc            <= fetch_base + BLK_BYTES;
        inflight_base <= fetch_base;
        inflight_s    <= start_slot;
      end
      tail  <= tail + QW'(enq_n);
      head  <= head + QW'(pop_n);
      count <= count + enq_n - pop_n;
    end
  end

  // Slot i of the response lands at tail + (i - start slot); slots below the
  // start slot belong to addresses before the fetch PC and are dropped.
  always_ff @(posedge clk) begin
    if (reset && resp_take) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i >= int'(inflight_s)) begin
          q_pc[tail + QW'(i) - QW'(inflight_s)]    <= inflight_base + PC_W'(4 * i);
          q_instr[tail + QW'(i) - QW'(inflight_s)] <= bus.imem_rdata[i*INSTR_W +: INSTR_W];
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] drop_n;
  logic [32:0] drop_sum;

  assign drop_n   = 32'(count) + (inflight_v ? (32'(FETCH_W) - 32'(inflight_s)) : 32'd0);
  assign drop_sum = {1'b0, perf_flush_drop} + {1'b0, drop_n};

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_empty_cyc  <= '0;
      perf_flush_drop <= '0;
    end else begin
      if (bus.fetch_en && (count == '0) && (perf_empty_cyc != '1))
        perf_empty_cyc <= perf_empty_cyc + 32'd1;
      if (bus.redirect_en)
        perf_flush_drop <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_nw.sv
module tb_fetch_queue_nw;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_queue_nw_if #(.FETCH_W(2), .PC_W(32), .INSTR_W(32), .QDEPTH(8))  b2 ();
  fetch_queue_nw_if #(.FETCH_W(4), .PC_W(32), .INSTR_W(32), .QDEPTH(16)) b4 ();

`ifdef FETCH_PERF_EN
  logic [31:0] pe2, pf2, pe4, pf4;
`endif

  fetch_queue_nw #(.FETCH_W(2), .PC_W(32), .INSTR_W(32), .QDEPTH(8), .RESET_PC(32'h0)) u_dut2 (
    .clk(clk), .reset(reset), .bus(b2)
`ifdef FETCH_PERF_EN
    , .perf_empty_cyc(pe2), .perf_flush_drop(pf2)
`endif
  );

  fetch_queue_nw #(.FETCH_W(4), .PC_W(32), .INSTR_W(32), .QDEPTH(16), .RESET_PC(32'hFFFF_FFF0)) u_dut4 (
    .clk(clk), .reset(reset), .bus(b4)
`ifdef FETCH_PERF_EN
    , .perf_empty_cyc(pe4), .perf_flush_drop(pf4)
`endif
  );

  // Memory contents: word at byte address a is 0x11111111 * (a/4 + 1), mod 2^32.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  always @(posedge clk) begin
    if (b2.imem_req)
      for (int i = 0; i < 2; i++)
        b2.imem_rdata[i*32 +: 32] <= mem_word(b2.imem_addr + 32'(4 * i));
  end

  always @(posedge clk) begin
    if (b4.imem_req)
      for (int i = 0; i < 4; i++)
        b4.imem_rdata[i*32 +: 32] <= mem_word(b4.imem_addr + 32'(4 * i));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("q_bound2", 128'(b2.q_count <= 4'd8), 128'd1);
    chk("q_bound4", 128'(b4.q_count <= 5'd16), 128'd1);
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] p);
    chk({tag, "_valid"}, 128'(b2.if_valid), 128'(2'b11));
    chk({tag, "_pc"},    128'(b2.if_pc),    128'({p + 32'd4, p}));
    chk({tag, "_instr"}, 128'(b2.if_instr), 128'({mem_word(p + 32'd4), mem_word(p)}));
  endtask

  initial begin
    reset          = 1'b0;
    b2.fetch_en    = 1'b1;
    b2.redirect_en = 1'b0;
    b2.redirect_pc = '0;
    b2.out_ready   = 1'b0;
    b4.fetch_en    = 1'b0;
    b4.redirect_en = 1'b0;
    b4.redirect_pc = '0;
    b4.out_ready   = 1'b0;
    repeat (3) step();

    // Reset state (fetch_en high must not leak a request through reset)
    chk("rst_valid", 128'(b2.if_valid), 128'd0);
    chk("rst_qcnt",  128'(b2.q_count),  128'd0);
    chk("rst_req",   128'(b2.imem_req), 128'd0);
    chk("rst_addr",  128'(b2.imem_addr), 128'd0);
    chk("rst_pc",    128'(b2.if_pc),    128'd0);
    chk("rst_instr", 128'(b2.if_instr), 128'd0);
    chk("rst_qcnt4", 128'(b4.q_count),  128'd0);

    // Startup latency and steady-state streaming
    reset = 1'b1;
    b2.out_ready = 1'b1;
    #1;
    chk("t1_req0",  128'(b2.imem_req),  128'd1);
    chk("t1_addr0", 128'(b2.imem_addr), 128'h0);
    step();
    chk("t1_valid1", 128'(b2.if_valid),  128'd0);
    chk("t1_addr1",  128'(b2.imem_addr), 128'h8);
    step();
    exp_pc = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk_pair("t1_stream", exp_pc);
      chk("t1_req", 128'(b2.imem_req), 128'd1);
      step();
      exp_pc = exp_pc + 32'd8;
    end

    // Backpressure: queue fills to 8 and requests stop
    b2.out_ready = 1'b0;
    repeat (10) step();
    chk("t2_qcnt", 128'(b2.q_count),  128'd8);
    chk("t2_req",  128'(b2.imem_req), 128'd0);
    chk_pair("t2_hold", exp_pc);
    b2.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_pair("t2_drain", exp_pc);
      step();
      exp_pc = exp_pc + 32'd8;
    end

    // Redirect to an unaligned slot while a request is in flight
    b2.redirect_en = 1'b1;
    b2.redirect_pc = 32'h0000_000E;
    #1;
    chk("t3_req_redir", 128'(b2.imem_req), 128'd0);
    step();
    b2.redirect_en = 1'b0;
    #1;
    chk("t3_valid_a", 128'(b2.if_valid),  128'd0);
    chk("t3_qcnt_a",  128'(b2.q_count),   128'd0);
    chk("t3_req_a",   128'(b2.imem_req),  128'd1);
    chk("t3_addr_a",  128'(b2.imem_addr), 128'h8);
    step();
    chk("t3_valid_b", 128'(b2.if_valid),  128'd0);
    chk("t3_addr_b",  128'(b2.imem_addr), 128'h10);
    step();
    chk("t3_valid_c", 128'(b2.if_valid), 128'(2'b01));
    chk("t3_pc_c",    128'(b2.if_pc),    128'h0000_000C);
    chk("t3_instr_c", 128'(b2.if_instr), 128'h4444_4444);
    chk("t3_qcnt_c",  128'(b2.q_count),  128'd1);
    step();
    chk_pair("t3_next", 32'h10);

    // Redirect in the cycle a response arrives, with out_ready high
    b2.redirect_en = 1'b1;
    b2.redirect_pc = 32'h0000_0040;
    step();
    b2.redirect_en = 1'b0;
    #1;
    chk("t4_valid_a", 128'(b2.if_valid),  128'd0);
    chk("t4_qcnt_a",  128'(b2.q_count),   128'd0);
    chk("t4_addr_a",  128'(b2.imem_addr), 128'h40);
    step();
    chk("t4_valid_b", 128'(b2.if_valid), 128'd0);
    step();
    chk_pair("t4_s0", 32'h40);
    step();
    chk_pair("t4_s1", 32'h48);

    // Build an odd occupancy (5) then reset
    b2.out_ready   = 1'b0;
    b2.redirect_en = 1'b1;
    b2.redirect_pc = 32'h0000_0004;
    step();
    b2.redirect_en = 1'b0;
    #1;
    chk("t5_addr_r1", 128'(b2.imem_addr), 128'h0);
    repeat (4) step();
    chk("t5_qcnt5", 128'(b2.q_count), 128'd5);
    chk_pair("t5_head", 32'h4);
    reset = 1'b0;
    step();
    chk("t5_valid", 128'(b2.if_valid),  128'd0);
    chk("t5_pc",    128'(b2.if_pc),     128'd0);
    chk("t5_instr", 128'(b2.if_instr),  128'd0);
    chk("t5_qcnt",  128'(b2.q_count),   128'd0);
    chk("t5_req",   128'(b2.imem_req),  128'd0);
    chk("t5_addr",  128'(b2.imem_addr), 128'd0);
    reset = 1'b1;
    b2.out_ready = 1'b1;
    #1;
    chk("t5_req_rel",  128'(b2.imem_req),  128'd1);
    chk("t5_addr_rel", 128'(b2.imem_addr), 128'h0);
    step();
    step();
    chk_pair("t5_restart", 32'h0);

    // 4-wide instance: PC wrap across 2^32
    b2.fetch_en  = 1'b0;
    b4.fetch_en  = 1'b1;
    b4.out_ready = 1'b1;
    #1;
    chk("t6_req0",  128'(b4.imem_req),  128'd1);
    chk("t6_addr0", 128'(b4.imem_addr), 128'hFFFF_FFF0);
    step();
    chk("t6_addr1", 128'(b4.imem_addr), 128'h0);
    step();
    chk("t6_valid0", 128'(b4.if_valid), 128'hF);
    chk("t6_pc0",    128'(b4.if_pc),
        {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0});
    chk("t6_instr0", 128'(b4.if_instr),
        {mem_word(32'hFFFF_FFFC), mem_word(32'hFFFF_FFF8),
         mem_word(32'hFFFF_FFF4), mem_word(32'hFFFF_FFF0)});
    step();
    chk("t6_valid1", 128'(b4.if_valid), 128'hF);
    chk("t6_pc1",    128'(b4.if_pc),    {32'hC, 32'h8, 32'h4, 32'h0});
    chk("t6_instr1", 128'(b4.if_instr),
        {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
